// File: rtl/video_ctrl_pkg.sv
// Shared types and constants for the video frame controller: FSM states,
// sticky error bit positions and the shadow configuration record.
package video_ctrl_pkg;

   localparam int CFG_XW = 12;
   localparam int CFG_YW = 12;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam int ERR_EOL_EARLY = 0;
   localparam int ERR_EOL_LATE  = 1;
   localparam int ERR_SOF_EARLY = 2;
   localparam int ERR_NO_SOF    = 3;
   localparam int ERR_CFG       = 4;
   localparam int ERR_W         = 5;

   typedef struct packed {
      logic [CFG_XW-1:0] width;
      logic [CFG_YW-1:0] height;
      logic              bypass;
   } shadow_cfg_t;

   // A geometry is usable only when both dimensions are non-zero.
   function automatic logic cfg_valid(input logic [CFG_XW-1:0] w, input logic [CFG_YW-1:0] h);
      return (w != {CFG_XW{1'b0}}) && (h != {CFG_YW{1'b0}});
   endfunction

endpackage

// File: rtl/video_pos_counter.sv
// Pixel X/Y position tracker with end-of-line geometry checks. A restart
// treats the current beat as pixel (0,0) regardless of the stored position.
module video_pos_counter
   import video_ctrl_pkg::*;
#(
   parameter int XW = 12,
   parameter int YW = 12
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          restart,
   input  logic          tlast,
   input  logic [XW-1:0] width,
   input  logic [YW-1:0] height,
   output logic [XW-1:0] pix_x,
   output logic [YW-1:0] pix_y,
   output logic          eol_early,
   output logic          eol_late,
   output logic          frame_end
);

   localparam logic [XW-1:0] X_ONE = {{(XW-1){1'b0}}, 1'b1};
   localparam logic [YW-1:0] Y_ONE = {{(YW-1){1'b0}}, 1'b1};
   localparam logic [XW-1:0] X_MAX = {XW{1'b1}};

   logic [XW-1:0] cur_x_s, last_x_s, next_x_s;
   logic [YW-1:0] cur_y_s, last_y_s, next_y_s;

   // Position of the beat on the bus, geometry flags and the next position.
   always_comb begin
      if (restart) begin
         cur_x_s = {XW{1'b0}};
         cur_y_s = {YW{1'b0}};
      end else begin
         cur_x_s = pix_x;
         cur_y_s = pix_y;
      end
      last_x_s  = width - X_ONE;
      last_y_s  = height - Y_ONE;
      eol_early = en & tlast & (cur_x_s < last_x_s);
      eol_late  = en & ~tlast & (cur_x_s == last_x_s);
      frame_end = en & tlast & (cur_y_s == last_y_s);
      if (tlast && (cur_y_s == last_y_s)) begin
         next_x_s = {XW{1'b0}};
         next_y_s = {YW{1'b0}};
      end else if (tlast) begin
         next_x_s = {XW{1'b0}};
         next_y_s = cur_y_s + Y_ONE;
      end else if (cur_x_s == X_MAX) begin
         next_x_s = cur_x_s;
         next_y_s = cur_y_s;
      end else begin
         next_x_s = cur_x_s + X_ONE;
         next_y_s = cur_y_s;
      end
   end

   // Position registers advance only on counted beats.
   always_ff @(posedge clk) begin
      if (reset) begin
         pix_x <= {XW{1'b0}};
         pix_y <= {YW{1'b0}};
      end else if (en) begin
         pix_x <= next_x_s;
         pix_y <= next_y_s;
      end
   end

endmodule

// File: rtl/video_frame_ctrl.sv
// Frame-level controller snooping the video stream handshake: tracks position
// and frame count, commits host configuration at SOF and flags bad geometry.
module video_frame_ctrl
   import video_ctrl_pkg::*;
#(
   parameter int XW    = 12,
   parameter int YW    = 12,
   parameter int DEF_W = 1920,
   parameter int DEF_H = 1080,
   parameter int FCW   = 16
)(
   input  logic             aclk,
   input  logic             areset,
   input  logic             aclken,
   input  logic             s_axis_video_tvalid_in,
   input  logic             m_axis_video_tready_in,
   input  logic             s_axis_video_tuser_in,
   input  logic             s_axis_video_tlast_in,
   input  logic [XW-1:0]    cfg_width,
   input  logic [YW-1:0]    cfg_height,
   input  logic             cfg_bypass,
   input  logic             cfg_apply,
   input  logic             err_clr,
   output logic             bypass_out,
   output logic [XW-1:0]    pix_x,
   output logic [YW-1:0]    pix_y,
   output logic [FCW-1:0]   frame_cnt,
   output logic             frame_done,
   output logic             cfg_pending,
   output logic             in_frame,
   output logic [ERR_W-1:0] err_status
);

   localparam shadow_cfg_t CFG_RESET = '{width: CFG_XW'(DEF_W), height: CFG_YW'(DEF_H), bypass: 1'b1};
   localparam logic [FCW-1:0] FC_ONE = {{(FCW-1){1'b0}}, 1'b1};

   state_t           state_r;
   shadow_cfg_t      act_r, shadow_r, cfg_in_s, commit_s;
   logic             beat_s, sof_s, counted_s, apply_ok_s;
   logic             eol_early_s, eol_late_s, frame_end_s;
   logic [XW-1:0]    eff_width_s;
   logic [YW-1:0]    eff_height_s;
   logic [ERR_W-1:0] err_set_s;

   // Beat qualification, the configuration a SOF would commit, and error sources.
   always_comb begin
      beat_s     = s_axis_video_tvalid_in & m_axis_video_tready_in & aclken;
      sof_s      = beat_s & s_axis_video_tuser_in;
      counted_s  = sof_s | (beat_s & (state_r == ACTIVE));
      apply_ok_s = cfg_apply & cfg_valid(cfg_width, cfg_height);
      cfg_in_s   = '{width: cfg_width, height: cfg_height, bypass: cfg_bypass};
      if (apply_ok_s) begin
         commit_s = cfg_in_s;
      end else begin
         commit_s = shadow_r;
      end
      // The SOF pixel is already processed with the configuration it commits.
      if (sof_s) begin
         eff_width_s  = commit_s.width;
         eff_height_s = commit_s.height;
         bypass_out   = commit_s.bypass;
      end else begin
         eff_width_s  = act_r.width;
         eff_height_s = act_r.height;
         bypass_out   = act_r.bypass;
      end
      err_set_s                = {ERR_W{1'b0}};
      err_set_s[ERR_EOL_EARLY] = eol_early_s;
      err_set_s[ERR_EOL_LATE]  = eol_late_s;
      err_set_s[ERR_SOF_EARLY] = sof_s & (state_r == ACTIVE) &
                                 ((pix_x != {XW{1'b0}}) | (pix_y != {YW{1'b0}}));
      err_set_s[ERR_NO_SOF]    = beat_s & ~s_axis_video_tuser_in & (state_r == IDLE);
      err_set_s[ERR_CFG]       = cfg_apply & ~apply_ok_s;
   end

   video_pos_counter #(
      .XW (XW),
      .YW (YW)
   ) u_pos (
      .clk       (aclk),
      .reset     (areset),
      .en        (counted_s),
      .restart   (sof_s),
      .tlast     (s_axis_video_tlast_in),
      .width     (eff_width_s),
      .height    (eff_height_s),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .eol_early (eol_early_s),
      .eol_late  (eol_late_s),
      .frame_end (frame_end_s)
   );

   // Frame FSM, configuration shadow/commit, sticky errors and frame counter.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_r     <= IDLE;
         act_r       <= CFG_RESET;
         shadow_r    <= CFG_RESET;
         cfg_pending <= 1'b0;
         frame_cnt   <= {FCW{1'b0}};
         frame_done  <= 1'b0;
         err_status  <= {ERR_W{1'b0}};
      end else begin
         // Host-side controls are honoured even while the stream clock is disabled.
         err_status <= (err_clr ? {ERR_W{1'b0}} : err_status) | err_set_s;
         frame_done <= frame_end_s;
         if (apply_ok_s) begin
            shadow_r <= cfg_in_s;
         end
         if (sof_s) begin
            act_r       <= commit_s;
            cfg_pending <= 1'b0;
         end else if (apply_ok_s) begin
            cfg_pending <= 1'b1;
         end
         if (counted_s) begin
            state_r <= frame_end_s ? IDLE : ACTIVE;
         end
         if (frame_end_s) begin
            frame_cnt <= frame_cnt + FC_ONE;
         end
      end
   end

   assign in_frame = (state_r == ACTIVE);

endmodule

// File: tb/tb_video_frame_ctrl.sv
// Scoreboard bench for video_frame_ctrl: a spec-level model pushes expected
// post-edge state per driven cycle; the entry is popped and compared after the edge.
module tb_video_frame_ctrl;

   localparam int TB_FCW = 4;

   logic              aclk = 1'b0;
   logic              areset, aclken, tvalid, tready, tuser, tlast;
   logic [11:0]       cfg_width, cfg_height;
   logic              cfg_bypass, cfg_apply, err_clr;
   logic              bypass_out, frame_done, cfg_pending, in_frame;
   logic [11:0]       pix_x, pix_y;
   logic [TB_FCW-1:0] frame_cnt;
   logic [4:0]        err_status;

   typedef struct {
      logic [11:0]       x;
      logic [11:0]       y;
      logic [TB_FCW-1:0] cnt;
      logic [4:0]        err;
      logic              pend;
      logic              inf;
      logic              done;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_miss = 0;
   int   done_seen = 0;

   logic              m_active, m_pend, m_act_b, m_sh_b;
   logic [11:0]       m_x, m_y, m_act_w, m_act_h, m_sh_w, m_sh_h;
   logic [TB_FCW-1:0] m_cnt;
   logic [4:0]        m_err;

   always #5 aclk = ~aclk;

   video_frame_ctrl #(.FCW(TB_FCW)) dut (
      .aclk                   (aclk),
      .areset                 (areset),
      .aclken                 (aclken),
      .s_axis_video_tvalid_in (tvalid),
      .m_axis_video_tready_in (tready),
      .s_axis_video_tuser_in  (tuser),
      .s_axis_video_tlast_in  (tlast),
      .cfg_width              (cfg_width),
      .cfg_height             (cfg_height),
      .cfg_bypass             (cfg_bypass),
      .cfg_apply              (cfg_apply),
      .err_clr                (err_clr),
      .bypass_out             (bypass_out),
      .pix_x                  (pix_x),
      .pix_y                  (pix_y),
      .frame_cnt              (frame_cnt),
      .frame_done             (frame_done),
      .cfg_pending            (cfg_pending),
      .in_frame               (in_frame),
      .err_status             (err_status)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_miss++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0; m_pend = 1'b0; m_x = 12'd0; m_y = 12'd0;
      m_cnt = '0; m_err = 5'd0;
      m_act_w = 12'd1920; m_act_h = 12'd1080; m_act_b = 1'b1;
      m_sh_w  = 12'd1920; m_sh_h  = 12'd1080; m_sh_b  = 1'b1;
   endtask

   // One clock of stimulus: model predicts, bypass checked pre-edge, state post-edge.
   task automatic cyc(input logic v, input logic r, input logic u, input logic l,
                      input logic en, input logic ap, input logic [11:0] w,
                      input logic [11:0] h, input logic b, input logic clr);
      exp_t        e;
      logic        beat, sof, ok, cb, eb;
      logic [11:0] cw, ch, ew, eh, px, py;
      logic [4:0]  set;
      logic        done;
      @(negedge aclk);
      tvalid = v; tready = r; tuser = u; tlast = l; aclken = en;
      cfg_apply = ap; cfg_width = w; cfg_height = h; cfg_bypass = b; err_clr = clr;
      beat = v & r & en;
      sof  = beat & u;
      ok   = ap && (w != 12'd0) && (h != 12'd0);
      cw = ok ? w : m_sh_w;
      ch = ok ? h : m_sh_h;
      cb = ok ? b : m_sh_b;
      eb = sof ? cb : m_act_b;
      set = 5'd0;
      done = 1'b0;
      if (ap && !ok) set[4] = 1'b1;
      if (beat) begin
         if (!m_active && !u) begin
            set[3] = 1'b1;
         end else begin
            if (sof && m_active && (m_x != 12'd0 || m_y != 12'd0)) set[2] = 1'b1;
            px = sof ? 12'd0 : m_x;
            py = sof ? 12'd0 : m_y;
            ew = sof ? cw : m_act_w;
            eh = sof ? ch : m_act_h;
            if (l && px < ew - 12'd1) set[0] = 1'b1;
            if (!l && px == ew - 12'd1) set[1] = 1'b1;
            if (l && py == eh - 12'd1) begin
               done = 1'b1; m_x = 12'd0; m_y = 12'd0; m_active = 1'b0; m_cnt = m_cnt + 1'b1;
            end else begin
               m_active = 1'b1;
               if (l) begin
                  m_x = 12'd0; m_y = py + 12'd1;
               end else begin
                  m_x = (px == 12'hFFF) ? px : px + 12'd1; m_y = py;
               end
            end
         end
      end
      if (sof) begin
         m_act_w = cw; m_act_h = ch; m_act_b = cb; m_pend = 1'b0;
      end else if (ok) begin
         m_pend = 1'b1;
      end
      if (ok) begin
         m_sh_w = w; m_sh_h = h; m_sh_b = b;
      end
      m_err = (clr ? 5'd0 : m_err) | set;
      e = '{x: m_x, y: m_y, cnt: m_cnt, err: m_err, pend: m_pend, inf: m_active, done: done};
      exp_q.push_back(e);
      #1;
      chk("bypass_out", 32'(bypass_out), 32'(eb));
      @(posedge aclk);
      #1;
      e = exp_q.pop_front();
      chk("pix_x", 32'(pix_x), 32'(e.x));
      chk("pix_y", 32'(pix_y), 32'(e.y));
      chk("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
      chk("err_status", 32'(err_status), 32'(e.err));
      chk("cfg_pending", 32'(cfg_pending), 32'(e.pend));
      chk("in_frame", 32'(in_frame), 32'(e.inf));
      chk("frame_done", 32'(frame_done), 32'(e.done));
      if (frame_done) done_seen++;
   endtask

   task automatic beat(input logic u, input logic l);
      cyc(1'b1, 1'b1, u, l, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
   endtask

   task automatic apply(input logic [11:0] w, input logic [11:0] h, input logic b);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, w, h, b, 1'b0);
   endtask

   task automatic clear();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1);
   endtask

   task automatic row4();
      for (int i = 0; i < 4; i++) beat(1'b0, i == 3);
   endtask

   task automatic do_reset();
      @(negedge aclk);
      areset = 1'b1;
      tvalid = 1'b0; tready = 1'b0; tuser = 1'b0; tlast = 1'b0; aclken = 1'b1;
      cfg_apply = 1'b0; err_clr = 1'b0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      areset = 1'b0;
      model_reset();
      exp_q.delete();
      chk("rst_pix_x", 32'(pix_x), 32'd0);
      chk("rst_pix_y", 32'(pix_y), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_err", 32'(err_status), 32'd0);
      chk("rst_pending", 32'(cfg_pending), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_in_frame", 32'(in_frame), 32'd0);
      chk("rst_bypass", 32'(bypass_out), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int q;
      int n;
      logic v, r, en;
      areset = 1'b1; aclken = 1'b1; tvalid = 1'b0; tready = 1'b0; tuser = 1'b0; tlast = 1'b0;
      cfg_width = 12'd0; cfg_height = 12'd0; cfg_bypass = 1'b0; cfg_apply = 1'b0; err_clr = 1'b0;
      model_reset();

      // 4x3 frame, bypass off from the SOF pixel
      do_reset();
      apply(12'd4, 12'd3, 1'b0);
      chk("t1_pending", 32'(cfg_pending), 32'd1);
      d0 = done_seen;
      for (int i = 0; i < 12; i++) beat(i == 0, (i % 4) == 3);
      chk("t1_done_pulses", 32'(done_seen - d0), 32'd1);
      chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("t1_err", 32'(err_status), 32'd0);

      // early and late end-of-line
      beat(1'b1, 1'b0);
      beat(1'b0, 1'b1);
      chk("t2_eol_early", 32'(err_status), 32'h01);
      chk("t2_pix_y", 32'(pix_y), 32'd1);
      for (int i = 0; i < 4; i++) beat(1'b0, 1'b0);
      beat(1'b0, 1'b1);
      chk("t2_eol_late", 32'(err_status), 32'h03);
      row4();
      chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);
      clear();
      chk("t2_cleared", 32'(err_status), 32'd0);

      // beats outside a frame, clear, and set-vs-clear priority
      beat(1'b0, 1'b0);
      beat(1'b0, 1'b0);
      chk("t3_no_sof", 32'(err_status), 32'h08);
      chk("t3_pix_x", 32'(pix_x), 32'd0);
      clear();
      chk("t3_cleared", 32'(err_status), 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1);
      chk("t3_set_wins", 32'(err_status), 32'h08);
      clear();

      // mid-frame apply, bad apply, early SOF at (2,1)
      beat(1'b1, 1'b0);
      beat(1'b0, 1'b0);
      apply(12'd4, 12'd3, 1'b1);
      chk("t4_pending", 32'(cfg_pending), 32'd1);
      beat(1'b0, 1'b0);
      beat(1'b0, 1'b1);
      beat(1'b0, 1'b0);
      beat(1'b0, 1'b0);
      chk("t4_pos_x", 32'(pix_x), 32'd2);
      chk("t4_pos_y", 32'(pix_y), 32'd1);
      apply(12'd0, 12'd3, 1'b0);
      chk("t4_cfg_err", 32'(err_status), 32'h10);
      beat(1'b1, 1'b0);
      chk("t4_sof_early", 32'(err_status), 32'h14);
      chk("t4_committed", 32'(cfg_pending), 32'd0);
      chk("t4_restart_x", 32'(pix_x), 32'd1);
      beat(1'b0, 1'b0);
      beat(1'b0, 1'b0);
      beat(1'b0, 1'b1);
      row4();
      row4();
      chk("t4_frame_cnt", 32'(frame_cnt), 32'd3);
      chk("t4_bypass_held", 32'(bypass_out), 32'd1);
      clear();

      // 1x1 frames with handshake and clock-enable gaps; counter wrap
      apply(12'd1, 12'd1, 1'b0);
      d0 = done_seen;
      q = 0;
      n = 0;
      while ((q < 20) && (n < 400)) begin
         v  = 1'($urandom_range(0, 1));
         r  = 1'($urandom_range(0, 1));
         en = ($urandom_range(0, 3) != 0);
         if (v && r && en) q++;
         cyc(v, r, 1'b1, 1'b1, en, !en, 12'd1, 12'd1, 1'b0, 1'b0);
         n++;
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
      chk("t5_enough_beats", 32'(q >= 20), 32'd1);
      chk("t5_done_vs_beats", 32'(done_seen - d0), 32'(q));
      chk("t5_cnt_wrap", 32'(frame_cnt), 32'((3 + q) % 16));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
